// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial add scheduler: default sizes,
// controller state encoding and a one-hot helper for grant generation.
package serial_add_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;
  localparam int MAX_NREQ  = 8;

  // Two-state controller: waiting for a request, or stepping the serial adder.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // One-hot vector sized for the largest supported requester count;
  // callers keep only the low NREQ bits.
  function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_NREQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/serial_add_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after
// the pointer, wrapping modulo NREQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            valid
);

  // Scan requesters starting at the pointer and latch onto the first hit.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/serial_add_scheduler.sv
// Shares one bit-serial full adder among NREQ requesters. A round-robin
// winner's operands are loaded into shift registers, added LSB first over
// WIDTH cycles, and the result is returned tagged with the requester index.
module serial_add_scheduler
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  input  logic [NREQ-1:0]       cin,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [WIDTH-1:0]      sum,
  output logic                  cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IDW-1:0]    done_id_q, done_id_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  logic [WIDTH-1:0]  sum_sr_q, sum_sr_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [IDW-1:0]      arb_winner;
  logic                arb_valid;
  logic                fa_s;
  logic                fa_c;
  logic [MAX_NREQ-1:0] winner_oh;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  // Single full adder working on the current LSBs and the running carry.
  always_comb begin
    fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    fa_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  end

  // Next-state logic: load on a won request, step the adder, publish on the last bit.
  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    sum_sr_d  = sum_sr_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    winner_oh = onehot(3'(arb_winner));

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          a_sr_d  = a_in[int'(arb_winner)*WIDTH +: WIDTH];
          b_sr_d  = b_in[int'(arb_winner)*WIDTH +: WIDTH];
          carry_d = cin[arb_winner];
          cnt_d   = '0;
          sel_d   = arb_winner;
          gnt_d   = winner_oh[NREQ-1:0];
          busy_d  = 1'b1;
          if (int'(arb_winner) == NREQ - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = arb_winner + 1'b1;
          end
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        carry_d  = fa_c;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = WIDTH'({fa_s, sum_sr_q} >> 1);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d     = sum_sr_d;
          cout_d    = fa_c;
          done_id_d = sel_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ptr_q     <= '0;
      sel_q     <= '0;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      sum_sr_q  <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      sum_sr_q  <= sum_sr_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum     = sum_q;
  assign cout    = cout_q;

endmodule
